// File: rtl/nor_flash_pkg.sv
// Shared constants for the NOR flash responder: command bytes, status-register
// bit positions, FSM state encoding and the status-byte formatter.
package nor_flash_pkg;

  localparam logic [7:0] CMD_READ_ARRAY   = 8'hFF;
  localparam logic [7:0] CMD_READ_STATUS  = 8'h70;
  localparam logic [7:0] CMD_READ_ID      = 8'h90;
  localparam logic [7:0] CMD_CLEAR_STATUS = 8'h50;
  localparam logic [7:0] CMD_PROG         = 8'h40;
  localparam logic [7:0] CMD_PROG_ALT     = 8'h10;
  localparam logic [7:0] CMD_ERASE        = 8'h20;
  localparam logic [7:0] CMD_CONFIRM      = 8'hD0;

  localparam logic [7:0] MFR_ID = 8'h89;

  localparam int SR_READY   = 7;
  localparam int SR_ERASE   = 5;
  localparam int SR_PROG    = 4;
  localparam int SR_PROTECT = 1;

  localparam logic [2:0] ST_READ_ARRAY  = 3'd0;
  localparam logic [2:0] ST_READ_STATUS = 3'd1;
  localparam logic [2:0] ST_READ_ID     = 3'd2;
  localparam logic [2:0] ST_PROG_SETUP  = 3'd3;
  localparam logic [2:0] ST_ERASE_SETUP = 3'd4;
  localparam logic [2:0] ST_PROG_BUSY   = 3'd5;
  localparam logic [2:0] ST_ERASE_BUSY  = 3'd6;

  typedef struct packed {
    logic sr5;
    logic sr4;
    logic sr1;
  } sr_t;

  function automatic logic [7:0] status_byte(input logic ready, input sr_t sr);
    logic [7:0] b;
    b             = 8'h00;
    b[SR_READY]   = ready;
    b[SR_ERASE]   = sr.sr5;
    b[SR_PROG]    = sr.sr4;
    b[SR_PROTECT] = sr.sr1;
    return b;
  endfunction

endpackage

// File: rtl/nor_flash_responder_if.sv
// 8-bit parallel NOR flash bus: the bridge is the master, the responder the slave.
interface nor_flash_responder_if #(
  parameter int ADDR_W = 8
) ();

  logic              NF_CE;
  logic              NF_OE;
  logic              NF_WE;
  logic              NF_RP;
  logic              NF_WP;
  logic              NF_BYTE;
  logic [ADDR_W-1:0] NF_A;
  logic [7:0]        NF_D_I;
  logic [7:0]        NF_D_O;
  logic              NF_D_OE;
  logic              NF_STS;

  modport master (
    output NF_CE, NF_OE, NF_WE, NF_RP, NF_WP, NF_BYTE, NF_A, NF_D_I,
    input  NF_D_O, NF_D_OE, NF_STS
  );

  modport slave (
    input  NF_CE, NF_OE, NF_WE, NF_RP, NF_WP, NF_BYTE, NF_A, NF_D_I,
    output NF_D_O, NF_D_OE, NF_STS
  );

endinterface

// File: rtl/nor_flash_array.sv
// Single-port 2^ADDR_W x 8 block RAM, erased (0xFF) at configuration,
// one-cycle read latency, read-before-write on a shared address.
module nor_flash_array #(
  parameter int ADDR_W = 8
) (
  input  logic              CLK_50MHZ,
  input  logic [ADDR_W-1:0] addr,
  input  logic              we,
  input  logic [7:0]        wdata,
  output logic [7:0]        rdata
);

  logic [7:0] mem [2**ADDR_W] = '{default: 8'hFF};

  // NOTE: the storage array has no reset; a reset loop would stop it mapping onto block RAM.
  always_ff @(posedge CLK_50MHZ) begin
    if (we) begin
      mem[addr] <= wdata;
    end
    rdata <= mem[addr];
  end

endmodule

// File: rtl/nor_flash_responder.sv
// Device end of the NOR flash CE/OE/WE strobe protocol: synchronises the strobes,
// decodes the StrataFlash command subset and emulates program/erase busy time.
module nor_flash_responder
  import nor_flash_pkg::*;
#(
  parameter int         ADDR_W       = 8,
  parameter int         PROG_CYCLES  = 500,
  parameter int         ERASE_CYCLES = 50000,
  parameter logic [7:0] DEVICE_ID    = 8'h16
) (
  input logic RST,
  input logic CLK_50MHZ,
  nor_flash_responder_if.slave bus
);

  localparam int CNT_MAX = (ERASE_CYCLES > PROG_CYCLES) ? ERASE_CYCLES : PROG_CYCLES;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);
  localparam logic [CNT_W-1:0] PROG_LAST  = CNT_W'(PROG_CYCLES - 1);
  localparam logic [CNT_W-1:0] ERASE_LAST = CNT_W'(ERASE_CYCLES - 1);
  localparam logic [CNT_W-1:0] SWEEP_END  = CNT_W'(2**ADDR_W);

  logic [1:0] ce_sync, oe_sync, we_sync, rp_sync, wp_sync;
  logic       ce_s, oe_s, we_s, rp_s, wp_s;

  // NOTE: sequential state uses <= so every flop samples pre-edge values.
  always_ff @(posedge CLK_50MHZ or posedge RST) begin
    if (RST) begin
      ce_sync <= 2'b11;
      oe_sync <= 2'b11;
      we_sync <= 2'b11;
      rp_sync <= 2'b11;
      wp_sync <= 2'b11;
    end else begin
      ce_sync <= {ce_sync[0], bus.NF_CE};
      oe_sync <= {oe_sync[0], bus.NF_OE};
      we_sync <= {we_sync[0], bus.NF_WE};
      rp_sync <= {rp_sync[0], bus.NF_RP};
      wp_sync <= {wp_sync[0], bus.NF_WP};
    end
  end

  assign ce_s = ce_sync[1];
  assign oe_s = oe_sync[1];
  assign we_s = we_sync[1];
  assign rp_s = rp_sync[1];
  assign wp_s = wp_sync[1];

  logic [ADDR_W-1:0] a_q, a_reg, a_reg2;
  logic [7:0]        d_q;
  logic              we_d;
  logic              wr_evt;

  // a_q/d_q hold the bus while a write strobe is low; a_reg/a_reg2 pipeline the read address.
  always_ff @(posedge CLK_50MHZ or posedge RST) begin
    if (RST) begin
      a_q    <= '0;
      d_q    <= '0;
      we_d   <= 1'b1;
      a_reg  <= '0;
      a_reg2 <= '0;
    end else begin
      we_d   <= we_s;
      a_reg  <= bus.NF_A;
      a_reg2 <= a_reg;
      if (!ce_s && !we_s) begin
        a_q <= bus.NF_A;
        d_q <= bus.NF_D_I;
      end
    end
  end

  assign wr_evt = we_s & ~we_d & ~ce_s;

  logic [2:0]        state;
  sr_t               sr;
  logic [CNT_W-1:0]  cnt;
  logic [ADDR_W-1:0] prog_a;
  logic [7:0]        prog_d;
  logic              busy;
  logic              protected_addr;
  logic [ADDR_W-1:0] ram_addr;
  logic              ram_we;
  logic [7:0]        ram_wdata;
  logic [7:0]        ram_q;
  logic              prog_fail;

  assign busy           = (state == ST_PROG_BUSY) || (state == ST_ERASE_BUSY);
  assign protected_addr = (a_q < ADDR_W'(16)) && !wp_s;
  assign prog_fail      = (ram_q & prog_d) != prog_d;

  always_ff @(posedge CLK_50MHZ or posedge RST) begin
    if (RST) begin
      state  <= ST_READ_ARRAY;
      sr     <= '0;
      cnt    <= '0;
      prog_a <= '0;
      prog_d <= '0;
    end else if (!rp_s) begin
      state <= ST_READ_ARRAY;
      sr    <= '0;
      cnt   <= '0;
    end else begin
      case (state)
        ST_PROG_SETUP: begin
          if (wr_evt) begin
            prog_a <= a_q;
            prog_d <= d_q;
            if (protected_addr) begin
              sr.sr1 <= 1'b1;
              sr.sr4 <= 1'b1;
              state  <= ST_READ_STATUS;
            end else begin
              cnt   <= '0;
              state <= ST_PROG_BUSY;
            end
          end
        end
        ST_ERASE_SETUP: begin
          if (wr_evt) begin
            state <= ST_READ_STATUS;
            if (d_q != CMD_CONFIRM) begin
              sr.sr4 <= 1'b1;
              sr.sr5 <= 1'b1;
            end else if (!wp_s) begin
              sr.sr1 <= 1'b1;
              sr.sr5 <= 1'b1;
            end else begin
              cnt   <= '0;
              state <= ST_ERASE_BUSY;
            end
          end
        end
        ST_PROG_BUSY: begin
          // ram_q holds the old byte during busy cycle 0, when the AND-write lands.
          if (cnt == '0 && prog_fail) begin
            sr.sr4 <= 1'b1;
          end
          if (cnt == PROG_LAST) begin
            state <= ST_READ_STATUS;
          end
          cnt <= cnt + CNT_W'(1);
        end
        ST_ERASE_BUSY: begin
          if (cnt == ERASE_LAST) begin
            state <= ST_READ_STATUS;
          end
          cnt <= cnt + CNT_W'(1);
        end
        default: begin
          if (wr_evt) begin
            case (d_q)
              CMD_READ_ARRAY:          state <= ST_READ_ARRAY;
              CMD_READ_STATUS:         state <= ST_READ_STATUS;
              CMD_READ_ID:             state <= ST_READ_ID;
              CMD_CLEAR_STATUS:        sr    <= '0;
              CMD_PROG, CMD_PROG_ALT:  state <= ST_PROG_SETUP;
              CMD_ERASE:               state <= ST_ERASE_SETUP;
              default: ;
            endcase
          end
        end
      endcase
    end
  end

  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    ram_addr  = a_reg;
    ram_we    = 1'b0;
    ram_wdata = ram_q & prog_d;
    case (state)
      ST_PROG_SETUP: ram_addr = a_q;
      ST_PROG_BUSY: begin
        ram_addr = prog_a;
        ram_we   = (cnt == '0) && rp_s;
      end
      ST_ERASE_BUSY: begin
        ram_addr  = cnt[ADDR_W-1:0];
        ram_we    = (cnt < SWEEP_END) && rp_s;
        ram_wdata = 8'hFF;
      end
      default: ;
    endcase
  end

  nor_flash_array #(.ADDR_W(ADDR_W)) u_array (
    .CLK_50MHZ (CLK_50MHZ),
    .addr      (ram_addr),
    .we        (ram_we),
    .wdata     (ram_wdata),
    .rdata     (ram_q)
  );

  logic [7:0] read_mux;
  logic [7:0] d_o;
  logic       d_oe;

  always_comb begin
    read_mux = status_byte(~busy, sr);
    case (state)
      ST_READ_ARRAY: read_mux = ram_q;
      ST_READ_ID: begin
        if (a_reg2 == ADDR_W'(0)) begin
          read_mux = MFR_ID;
        end else if (a_reg2 == ADDR_W'(1)) begin
          read_mux = DEVICE_ID;
        end else begin
          read_mux = 8'h00;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge CLK_50MHZ or posedge RST) begin
    if (RST) begin
      d_o  <= 8'h00;
      d_oe <= 1'b0;
    end else if (!rp_s) begin
      d_o  <= 8'h00;
      d_oe <= 1'b0;
    end else begin
      d_o  <= read_mux;
      d_oe <= ~ce_s & ~oe_s & we_s;
    end
  end

  assign bus.NF_D_O  = d_o;
  assign bus.NF_D_OE = d_oe;
  assign bus.NF_STS  = ~busy;

  // Byte-mode strap is fixed to 8-bit operation and otherwise has no effect.
  logic unused_byte;
  assign unused_byte = bus.NF_BYTE;

endmodule

// File: tb/tb_nor_flash_responder.sv
// Directed + randomized bench for nor_flash_responder against a byte-array
// reference model of the flash command set.
module tb_nor_flash_responder;

  localparam int         ADDR_W       = 8;
  localparam int         DEPTH        = 256;
  localparam int         PROG_CYCLES  = 500;
  localparam int         ERASE_CYCLES = 50000;
  localparam logic [7:0] DEVICE_ID    = 8'h16;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   tests = 0;
  int   fails = 0;

  always #10 clk = ~clk;

  nor_flash_responder_if #(.ADDR_W(ADDR_W)) bus ();

  nor_flash_responder #(
    .ADDR_W       (ADDR_W),
    .PROG_CYCLES  (PROG_CYCLES),
    .ERASE_CYCLES (ERASE_CYCLES),
    .DEVICE_ID    (DEVICE_ID)
  ) dut (
    .RST       (rst),
    .CLK_50MHZ (clk),
    .bus       (bus)
  );

  // Reference model: byte array plus the three sticky status bits.
  logic [7:0] m_mem [DEPTH];
  bit         m_sr5, m_sr4, m_sr1;

  function automatic logic [7:0] exp_status(input bit ready);
    return {ready, 1'b0, m_sr5, m_sr4, 2'b00, m_sr1, 1'b0};
  endfunction

  task automatic model_program(input int a, input logic [7:0] d, input bit wp);
    if (a < 16 && !wp) begin
      m_sr1 = 1'b1;
      m_sr4 = 1'b1;
    end else begin
      if ((m_mem[a] & d) != d) m_sr4 = 1'b1;
      m_mem[a] = m_mem[a] & d;
    end
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  task automatic write_cmd(input logic [7:0] a, input logic [7:0] d);
    bus.NF_OE  = 1'b1;
    bus.NF_A   = a;
    bus.NF_D_I = d;
    bus.NF_CE  = 1'b0;
    tick(1);
    bus.NF_WE = 1'b0;
    tick(3);
    bus.NF_WE = 1'b1;
    tick(4);
  endtask

  task automatic read_at(input logic [7:0] a, output logic [7:0] data, output logic oe);
    bus.NF_WE = 1'b1;
    bus.NF_A  = a;
    bus.NF_CE = 1'b0;
    bus.NF_OE = 1'b0;
    tick(3);
    @(negedge clk);
    data = bus.NF_D_O;
    oe   = bus.NF_D_OE;
    tick(1);
  endtask

  task automatic wait_ready(input int budget);
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (bus.NF_STS === 1'b1) break;
    end
    check("ready_bound", 32'(bus.NF_STS), 32'd1);
    tick(1);
  endtask

  // Confirming write followed by a cycle-accurate count of STS-low cycles.
  task automatic timed_confirm(input logic [7:0] a, input logic [7:0] d, input int budget,
                               input int probe_at, input int abort_at,
                               output int busy, output logic [7:0] probe, output logic sts_ab);
    bit done;
    busy   = 0;
    done   = 1'b0;
    probe  = 'x;
    sts_ab = 'x;
    bus.NF_OE  = 1'b1;
    bus.NF_A   = a;
    bus.NF_D_I = d;
    bus.NF_CE  = 1'b0;
    tick(1);
    bus.NF_WE = 1'b0;
    tick(3);
    bus.NF_WE = 1'b1;
    for (int i = 0; i < budget && !done; i++) begin
      @(negedge clk);
      if (bus.NF_STS === 1'b0) begin
        busy++;
        if (busy == probe_at - 10) bus.NF_OE = 1'b0;
        if (busy == probe_at) probe = bus.NF_D_O;
        if (abort_at != 0 && busy == abort_at) begin
          rst = 1'b1;
          #1;
          sts_ab = bus.NF_STS;
          done   = 1'b1;
        end
      end else if (busy > 0) begin
        done = 1'b1;
      end
    end
    check("busy_bound", 32'(done), 32'd1);
    bus.NF_OE = 1'b1;
    tick(2);
    rst = 1'b0;
    tick(2);
  endtask

  task automatic do_program(input logic [7:0] a, input logic [7:0] d);
    write_cmd(8'h00, 8'h40);
    write_cmd(a, d);
    wait_ready(2 * PROG_CYCLES);
    model_program(int'(a), d, bus.NF_WP);
  endtask

  initial begin
    logic [7:0] rd, probe, a, d;
    logic       oe, sts_ab;
    int         busy;
    bit         wp;

    foreach (m_mem[i]) m_mem[i] = 8'hFF;
    bus.NF_CE   = 1'b1;
    bus.NF_OE   = 1'b1;
    bus.NF_WE   = 1'b1;
    bus.NF_RP   = 1'b1;
    bus.NF_WP   = 1'b1;
    bus.NF_BYTE = 1'b0;
    bus.NF_A    = '0;
    bus.NF_D_I  = '0;

    // Reset state
    tick(3);
    @(negedge clk);
    check("rst_sts", 32'(bus.NF_STS), 32'd1);
    check("rst_doe", 32'(bus.NF_D_OE), 32'd0);
    check("rst_do", 32'(bus.NF_D_O), 32'h00);
    rst = 1'b0;
    tick(2);

    // Power-up read latency: output enabled on the 3rd edge, not the 2nd
    bus.NF_A  = 8'h33;
    bus.NF_CE = 1'b0;
    bus.NF_OE = 1'b0;
    tick(2);
    @(negedge clk);
    check("lat_doe_early", 32'(bus.NF_D_OE), 32'd0);
    tick(1);
    @(negedge clk);
    check("lat_doe", 32'(bus.NF_D_OE), 32'd1);
    check("lat_do", 32'(bus.NF_D_O), 32'hFF);
    check("lat_sts", 32'(bus.NF_STS), 32'd1);

    // First program: busy length and in-busy status
    write_cmd(8'h00, 8'h40);
    timed_confirm(8'h20, 8'hA5, 4 * PROG_CYCLES, 20, 0, busy, probe, sts_ab);
    check("prog_busy_len", 32'(busy), 32'(PROG_CYCLES));
    check("prog_busy_status", 32'(probe), 32'(exp_status(1'b0)));
    model_program(32'h20, 8'hA5, 1'b1);
    read_at(8'h00, rd, oe);
    check("prog_status", 32'(rd), 32'(exp_status(1'b1)));
    check("prog_status_oe", 32'(oe), 32'd1);
    write_cmd(8'h00, 8'hFF);
    read_at(8'h20, rd, oe);
    check("prog_data", 32'(rd), 32'(m_mem[8'h20]));

    // Second program cannot set bits back to 1
    do_program(8'h20, 8'h5A);
    read_at(8'h00, rd, oe);
    check("reprog_status", 32'(rd), 32'(exp_status(1'b1)));
    write_cmd(8'h00, 8'hFF);
    read_at(8'h20, rd, oe);
    check("reprog_data", 32'(rd), 32'(m_mem[8'h20]));

    // Protected block
    bus.NF_WP = 1'b0;
    tick(3);
    write_cmd(8'h00, 8'h40);
    write_cmd(8'h05, 8'h12);
    @(negedge clk);
    check("prot_no_busy", 32'(bus.NF_STS), 32'd1);
    model_program(5, 8'h12, 1'b0);
    read_at(8'h00, rd, oe);
    check("prot_status", 32'(rd), 32'(exp_status(1'b1)));
    write_cmd(8'h00, 8'hFF);
    read_at(8'h05, rd, oe);
    check("prot_data", 32'(rd), 32'(m_mem[5]));
    bus.NF_WP = 1'b1;
    write_cmd(8'h00, 8'h70);
    write_cmd(8'h00, 8'h50);
    m_sr1 = 0; m_sr4 = 0; m_sr5 = 0;
    read_at(8'h00, rd, oe);
    check("clear_status", 32'(rd), 32'(exp_status(1'b1)));

    // Read ID
    write_cmd(8'h00, 8'h90);
    read_at(8'h00, rd, oe);
    check("id_mfr", 32'(rd), 32'h89);
    read_at(8'h01, rd, oe);
    check("id_dev", 32'(rd), 32'(DEVICE_ID));
    read_at(8'h02, rd, oe);
    check("id_a2", 32'(rd), 32'h00);
    a = 8'($urandom_range(3, 255));
    read_at(a, rd, oe);
    check("id_rand", 32'(rd), 32'h00);

    // OE and WE low together: output stays off, the write still lands
    bus.NF_A   = 8'h00;
    bus.NF_D_I = 8'hFF;
    bus.NF_CE  = 1'b0;
    bus.NF_OE  = 1'b0;
    bus.NF_WE  = 1'b0;
    tick(4);
    @(negedge clk);
    check("oe_we_low_doe", 32'(bus.NF_D_OE), 32'd0);
    bus.NF_WE = 1'b1;
    tick(4);
    read_at(8'h20, rd, oe);
    check("oe_we_write", 32'(rd), 32'(m_mem[8'h20]));

    // Randomized programs against the model
    for (int it = 0; it < 6; it++) begin
      write_cmd(8'h00, 8'h50);
      m_sr1 = 0; m_sr4 = 0; m_sr5 = 0;
      wp = ($urandom_range(0, 3) != 0);
      a  = ($urandom_range(0, 3) == 0) ? 8'($urandom_range(0, 15)) : 8'($urandom_range(0, 255));
      d  = 8'($urandom);
      bus.NF_WP = wp;
      tick(3);
      do_program(a, d);
      read_at(8'h00, rd, oe);
      check("rand_status", 32'(rd), 32'(exp_status(1'b1)));
      write_cmd(8'h00, 8'hFF);
      read_at(a, rd, oe);
      check("rand_data", 32'(rd), 32'(m_mem[a]));
      bus.NF_WP = 1'b1;
      tick(3);
    end

    // A write event during busy is ignored
    write_cmd(8'h00, 8'h50);
    m_sr1 = 0; m_sr4 = 0; m_sr5 = 0;
    write_cmd(8'h00, 8'h40);
    write_cmd(8'h30, 8'h3C);
    write_cmd(8'h00, 8'h90);
    wait_ready(2 * PROG_CYCLES);
    model_program(32'h30, 8'h3C, 1'b1);
    read_at(8'h00, rd, oe);
    check("busy_write_ignored", 32'(rd), 32'(exp_status(1'b1)));

    // Full erase
    write_cmd(8'h00, 8'h50);
    m_sr1 = 0; m_sr4 = 0; m_sr5 = 0;
    do_program(8'h40, 8'h00);
    write_cmd(8'h00, 8'h20);
    timed_confirm(8'h00, 8'hD0, ERASE_CYCLES + 1000, 1000, 0, busy, probe, sts_ab);
    check("erase_busy_len", 32'(busy), 32'(ERASE_CYCLES));
    check("erase_busy_status", 32'(probe), 32'(exp_status(1'b0)));
    foreach (m_mem[i]) m_mem[i] = 8'hFF;
    read_at(8'h00, rd, oe);
    check("erase_status", 32'(rd), 32'(exp_status(1'b1)));
    write_cmd(8'h00, 8'hFF);
    for (int i = 0; i < DEPTH; i++) begin
      read_at(8'(i), rd, oe);
      check("erase_data", 32'(rd), 32'(m_mem[i]));
    end

    // Erase sequence error and protected erase
    write_cmd(8'h00, 8'h20);
    write_cmd(8'h00, 8'h55);
    m_sr4 = 1; m_sr5 = 1;
    @(negedge clk);
    check("erase_seq_no_busy", 32'(bus.NF_STS), 32'd1);
    read_at(8'h00, rd, oe);
    check("erase_seq_status", 32'(rd), 32'(exp_status(1'b1)));
    write_cmd(8'h00, 8'h50);
    m_sr1 = 0; m_sr4 = 0; m_sr5 = 0;
    bus.NF_WP = 1'b0;
    tick(3);
    write_cmd(8'h00, 8'h20);
    write_cmd(8'h00, 8'hD0);
    m_sr1 = 1; m_sr5 = 1;
    @(negedge clk);
    check("erase_wp_no_busy", 32'(bus.NF_STS), 32'd1);
    read_at(8'h00, rd, oe);
    check("erase_wp_status", 32'(rd), 32'(exp_status(1'b1)));
    bus.NF_WP = 1'b1;
    tick(3);

    // Erase aborted by reset at busy cycle 100
    write_cmd(8'h00, 8'h50);
    m_sr1 = 0; m_sr4 = 0; m_sr5 = 0;
    do_program(8'h10, 8'($urandom_range(0, 254)));
    do_program(8'h63, 8'($urandom_range(0, 254)));
    do_program(8'h64, 8'($urandom_range(0, 254)));
    do_program(8'hC8, 8'($urandom_range(0, 254)));
    write_cmd(8'h00, 8'h20);
    timed_confirm(8'h00, 8'hD0, ERASE_CYCLES + 1000, 0, 101, busy, probe, sts_ab);
    check("abort_sts", 32'(sts_ab), 32'd1);
    for (int i = 0; i < 100; i++) m_mem[i] = 8'hFF;
    m_sr1 = 0; m_sr4 = 0; m_sr5 = 0;
    for (int i = 0; i < DEPTH; i++) begin
      read_at(8'(i), rd, oe);
      check("abort_data", 32'(rd), 32'(m_mem[i]));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
